uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Shares the single UART transmitter in the PC interface between two byte-stream requesters: requester 0 carries `packet_decode` response packets and requester 1 carries asynchronous debug/event packets. Packets are atomic: once a requester is granted, every byte up to and including its `last` byte is sent before the other requester is served. Ties are resolved round-robin. An idle timeout prevents a stalled requester from holding the line. The block sits between the requesters and the `uart` instance, and drives `transmit`/`tx_byte` from the UART's `is_transmitting` status.

## Interface
- `TIMEOUT`, 65535: idle cycles allowed in HOLD before the grant is revoked; 0 disables the timeout.
- `TIMEOUT_W`, 16: width of the timeout counter; must satisfy `TIMEOUT < 2**TIMEOUT_W`.
- `wb_clk`  in  1  sole clock, rising edge.
- `wb_rst`  in  1  reset, asynchronous assert, active-low.
- `s0_valid`  in  1  requester 0 has a byte.
- `s0_data`  in  8  requester 0 byte.
- `s0_last`  in  1  requester 0 byte is the final byte of its packet.
- `s0_ready`  out  1  requester 0 byte accepted this cycle when `s0_valid` is also 1.
- `s1_valid`, `s1_data[7:0]`, `s1_last`, `s1_ready`: same as requester 0, for requester 1.
- `transmit`  out  1  one-cycle start pulse to the UART.
- `tx_byte`  out  8  byte to the UART; stable from SEND until the next capture.
- `is_transmitting`  in  1  UART busy.
- `grant`  out  2  one-hot current owner; 00 when none.
- `busy`  out  1  state is not IDLE.
- `timeout_err`  out  1  one-cycle pulse when a grant is revoked by timeout.

## Operation
- States: IDLE, HOLD, SEND, WAIT_START, WAIT_DONE.
- IDLE: when `is_transmitting`=0 and at least one `valid`=1, grant that requester and go to HOLD. If both are valid, grant the requester that is not `last_served`. `last_served` resets to 1, so requester 0 wins the first tie.
- HOLD: `sN_ready` equals `grant[N]`.
  - On `valid & ready`, capture `data` into `tx_byte` and `last` into `last_r`, then go to SEND.
  - Otherwise, increment the timeout counter.
- SEND: `transmit`=1 for exactly one cycle, then go to WAIT_START.
- WAIT_START: wait for `is_transmitting`=1, then go to WAIT_DONE.
- WAIT_DONE: wait for `is_transmitting`=0.
  - If `last_r`=1: set `last_served` to the owner, clear `grant`, go to IDLE.
  - Otherwise: return to HOLD with the counter cleared.
- Timeout: the counter clears on entry to HOLD and on each handshake. If the counter reaches `TIMEOUT` while in HOLD with no handshake, the block:
  - pulses `timeout_err`;
  - sets `last_served` to the owner;
  - clears `grant`;
  - goes to IDLE.
- A byte presented in the timeout cycle is not accepted.
- The non-granted requester's `ready` is always 0. Its `valid`/`data` may change freely.
- A requester may drop `valid` in HOLD without penalty other than the timeout.
- A single-byte packet has `last`=1 on its first byte.
- Reset values: `transmit`=0, `tx_byte`=0, `s0_ready`=`s1_ready`=0, `grant`=00, `busy`=0, `timeout_err`=0, state=IDLE, counter=0, `last_r`=0, `last_served`=1.
- Reset mid-operation: all state clears immediately. The UART may still be finishing a frame, so IDLE does not grant until `is_transmitting`=0.

## Timing
- First byte: `valid` rises at cycle 0 in IDLE → `grant` and `ready` at cycle 1 (handshake) → `transmit` at cycle 2.
- Next byte of the same packet: `is_transmitting` is observed low at cycle t → HOLD at t+1 (handshake if `valid`) → `transmit` at t+2.
- Packet switch: the last byte's `is_transmitting` falls at cycle t → IDLE at t+1 → new grant at t+2 → `transmit` at t+3.
- `ready` is a registered state decode. `ready` has no combinational path from `valid`.
- Timeout fires on the `TIMEOUT`-th consecutive idle HOLD cycle. `grant` is 00 the following cycle.

## Test plan
- Single packet on requester 0, bytes 0x55, 0xAA (`last` on 0xAA), UART model busy for 20 cycles per byte → exactly two `transmit` pulses, `tx_byte` 0x55 then 0xAA, `grant` 01 throughout, then 00.
- Both requesters assert simultaneously after reset, each with a 3-byte packet → requester 0's 3 bytes first, then requester 1's. On a second simultaneous request, requester 1 is served first.
- Requester 1 asserts `valid` while requester 0 is mid-packet → no interleaving; `s1_ready` stays 0 until requester 0's `last` byte completes.
- `TIMEOUT`=10: requester 0 sends a non-last byte, then drops `valid` → `timeout_err` pulses 10 cycles after HOLD entry; requester 1 (pending) is granted next.
- Reset is asserted while `is_transmitting`=1 and held for 50 cycles after release → all outputs are at reset values, and no `transmit` occurs until `is_transmitting` falls.
- Back-to-back single-byte packets from requester 1 alone → each `transmit` follows the previous `is_transmitting` fall by 3 cycles.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Two-requester packet arbiter in front of a single UART transmitter.
// Whole packets are forwarded atomically; ties alternate; a stalled owner is dropped after TIMEOUT idle cycles.
module uart_tx_arbiter #(
    parameter int TIMEOUT   = 65535,
    parameter int TIMEOUT_W = 16
) (
    input  logic       wb_clk,
    input  logic       wb_rst,
    input  logic       s0_valid,
    input  logic [7:0] s0_data,
    input  logic       s0_last,
    output logic       s0_ready,
    input  logic       s1_valid,
    input  logic [7:0] s1_data,
    input  logic       s1_last,
    output logic       s1_ready,
    output logic       transmit,
    output logic [7:0] tx_byte,
    input  logic       is_transmitting,
    output logic [1:0] grant,
    output logic       busy,
    output logic       timeout_err,
    output logic [2:0] dbg_state
);

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_HOLD       = 3'd1;
    localparam logic [2:0] ST_SEND       = 3'd2;
    localparam logic [2:0] ST_WAIT_START = 3'd3;
    localparam logic [2:0] ST_WAIT_DONE  = 3'd4;

    localparam bit                   TMO_EN   = (TIMEOUT != 0);
    localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [2:0]           state;
    logic [TIMEOUT_W-1:0] tmo_cnt;
    logic [1:0]           grant_r;
    logic [7:0]           tx_byte_r;
    logic                 last_r;
    logic                 last_served;
    logic                 tmo_err_r;

    logic       in_hold;
    logic       tmo_hit;
    logic       handshake;
    logic       pick1;
    logic [7:0] sel_data;
    logic       sel_last;

    // Handshake: a byte moves when sN_valid and sN_ready are both 1 at a rising edge.
    // sN_ready is decoded from registered state only, so it never depends on sN_valid;
    // it is withheld in the cycle the timeout fires so that cycle cannot also accept a byte.
    assign in_hold   = (state == ST_HOLD);
    assign tmo_hit   = TMO_EN && in_hold && (tmo_cnt == TMO_LAST);
    assign s0_ready  = in_hold & grant_r[0] & ~tmo_hit;
    assign s1_ready  = in_hold & grant_r[1] & ~tmo_hit;
    assign handshake = (s0_ready & s0_valid) | (s1_ready & s1_valid);
    assign sel_data  = grant_r[1] ? s1_data : s0_data;
    assign sel_last  = grant_r[1] ? s1_last : s0_last;

    // Requester 1 wins when alone, or on a tie when requester 0 was served last.
    assign pick1 = s1_valid & (~s0_valid | ~last_served);

    always_ff @(posedge wb_clk or negedge wb_rst) begin
        if (!wb_rst) begin
            state       <= ST_IDLE;
            tmo_cnt     <= '0;
            grant_r     <= 2'b00;
            tx_byte_r   <= 8'h00;
            last_r      <= 1'b0;
            last_served <= 1'b1;
            tmo_err_r   <= 1'b0;
        end else begin
            tmo_err_r <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!is_transmitting && (s0_valid || s1_valid)) begin
                        grant_r <= pick1 ? 2'b10 : 2'b01;
                        tmo_cnt <= '0;
                        state   <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (handshake) begin
                        tx_byte_r <= sel_data;
                        last_r    <= sel_last;
                        tmo_cnt   <= '0;
                        state     <= ST_SEND;
                    end else if (tmo_hit) begin
                        tmo_err_r   <= 1'b1;
                        last_served <= grant_r[1];
                        grant_r     <= 2'b00;
                        state       <= ST_IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                ST_SEND: begin
                    state <= ST_WAIT_START;
                end
                ST_WAIT_START: begin
                    if (is_transmitting) begin
                        state <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (!is_transmitting) begin
                        if (last_r) begin
                            last_served <= grant_r[1];
                            grant_r     <= 2'b00;
                            state       <= ST_IDLE;
                        end else begin
                            tmo_cnt <= '0;
                            state   <= ST_HOLD;
                        end
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign transmit    = (state == ST_SEND);
    assign tx_byte     = tx_byte_r;
    assign grant       = grant_r;
    assign busy        = (state != ST_IDLE);
    assign timeout_err = tmo_err_r;
    assign dbg_state   = state;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural UART model, two requester drivers,
// a byte scoreboard keyed by owner, a table of arbitration vectors and directed corner sequences.
module tb_uart_tx_arbiter;

    logic       wb_clk;
    logic       wb_rst;
    logic       s0_valid, s0_last, s1_valid, s1_last;
    logic [7:0] s0_data, s1_data;
    logic       s0_ready, s1_ready;
    logic       transmit;
    logic [7:0] tx_byte;
    logic       is_transmitting;
    logic [1:0] grant;
    logic       busy;
    logic       timeout_err;
    logic [2:0] dbg_state;

    uart_tx_arbiter #(.TIMEOUT(10), .TIMEOUT_W(16)) dut (
        .wb_clk(wb_clk), .wb_rst(wb_rst),
        .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last), .s1_ready(s1_ready),
        .transmit(transmit), .tx_byte(tx_byte), .is_transmitting(is_transmitting),
        .grant(grant), .busy(busy), .timeout_err(timeout_err), .dbg_state(dbg_state)
    );

    // clock / reset
    initial begin
        wb_clk = 1'b0;
        forever #5 wb_clk = ~wb_clk;
    end

    int cyc = 0;
    always @(posedge wb_clk) cyc <= cyc + 1;

    // UART model: busy for 20 cycles after each start pulse; force_busy emulates a frame in flight
    int   uart_cnt = 0;
    logic force_busy;
    always @(posedge wb_clk) begin
        if (transmit) uart_cnt <= 20;
        else if (uart_cnt > 0) uart_cnt <= uart_cnt - 1;
    end
    assign is_transmitting = (uart_cnt != 0) || force_busy;

    // scoreboard
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [9:0] exp_q[$];
    logic       prev_it = 1'b0;
    int         last_fall = 0;
    bit         fall_seen = 1'b0;
    bit         gap_en = 1'b0;
    int         exp_gap = 0;
    int         tmo_seen = 0;
    int         tmo_gap = 0;
    logic [1:0] tmo_grant = 2'b11;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge wb_clk) begin
        if (wb_rst) begin
            if (prev_it && !is_transmitting) last_fall = cyc;
            if (!gap_en) fall_seen = 1'b0;
            else if (prev_it && !is_transmitting) fall_seen = 1'b1;
            if (transmit) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_transmit: got grant %b byte %02h expected none", grant, tx_byte);
                end else begin
                    check("tx_stream_grant_byte", {22'd0, grant, tx_byte}, {22'd0, exp_q.pop_front()});
                end
                if (gap_en && fall_seen) begin
                    check("fall_to_transmit_gap", cyc - last_fall, exp_gap);
                    fall_seen = 1'b0;
                end
            end
            n_cmp++;
            if ((s0_ready && !grant[0]) || (s1_ready && !grant[1])) begin
                n_bad++;
                $display("FAIL ready_vs_grant: got ready %b%b grant %b expected ready only on owner",
                         s1_ready, s0_ready, grant);
            end
            if (timeout_err) begin
                tmo_seen++;
                tmo_gap   = cyc - last_fall;
                tmo_grant = grant;
            end
        end
        prev_it = is_transmitting;
    end

    // driver tasks
    task automatic set_req(input int id, input logic v, input logic [7:0] d, input logic l);
        if (id == 0) begin
            s0_valid = v; s0_data = d; s0_last = l;
        end else begin
            s1_valid = v; s1_data = d; s1_last = l;
        end
    endtask

    task automatic send_pkt(input int id, input logic [23:0] bytes, input int n, input bit end_pkt);
        for (int i = 0; i < n; i++) begin
            int   waited;
            logic acc;
            set_req(id, 1'b1, bytes[8*i +: 8], end_pkt && (i == n - 1));
            waited = 0;
            acc    = 1'b0;
            while (!acc && waited < 3000) begin
                @(negedge wb_clk);
                acc = (id == 0) ? s0_ready : s1_ready;
                @(posedge wb_clk);
                #1;
                waited++;
            end
            if (!acc) begin
                n_cmp++;
                n_bad++;
                $display("FAIL accept_wait: got no ready for requester %0d byte %0d expected acceptance", id, i);
            end
        end
        set_req(id, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic push_pkt(input int id, input logic [23:0] bytes, input int n);
        for (int i = 0; i < n; i++)
            exp_q.push_back({(id == 1) ? 2'b10 : 2'b01, bytes[8*i +: 8]});
    endtask

    task automatic wait_idle();
        int k = 0;
        while ((busy || is_transmitting || exp_q.size() != 0) && k < 4000) begin
            @(negedge wb_clk);
            k++;
        end
        if (k >= 4000) begin
            n_cmp++;
            n_bad++;
            $display("FAIL idle_wait: got busy=%b pending=%0d expected idle", busy, exp_q.size());
        end
    endtask

    // arbitration vectors: which requesters present a packet, their bytes, and who is granted first
    typedef struct {
        logic [1:0]  req;
        logic [23:0] b0;
        int          n0;
        logic [23:0] b1;
        int          n1;
        logic [1:0]  first;
    } vec_t;

    vec_t vecs[7];
    vec_t cur;

    initial begin
        vecs[0] = '{req: 2'b11, b0: 24'h131211, n0: 3, b1: 24'h232221, n1: 3, first: 2'b01};
        vecs[1] = '{req: 2'b01, b0: 24'h000031, n0: 1, b1: 24'h000000, n1: 0, first: 2'b01};
        vecs[2] = '{req: 2'b11, b0: 24'h004241, n0: 2, b1: 24'h000051, n1: 1, first: 2'b10};
        vecs[3] = '{req: 2'b11, b0: 24'h000061, n0: 1, b1: 24'h007271, n1: 2, first: 2'b10};
        vecs[4] = '{req: 2'b10, b0: 24'h000000, n0: 0, b1: 24'h000081, n1: 1, first: 2'b10};
        vecs[5] = '{req: 2'b11, b0: 24'h0000C1, n0: 1, b1: 24'h0000D1, n1: 1, first: 2'b01};
        vecs[6] = '{req: 2'b01, b0: 24'h00AA55, n0: 2, b1: 24'h000000, n1: 0, first: 2'b01};

        wb_rst = 1'b0;
        force_busy = 1'b0;
        set_req(0, 1'b0, 8'h00, 1'b0);
        set_req(1, 1'b0, 8'h00, 1'b0);
        repeat (3) @(negedge wb_clk);
        check("reset_grant", {30'd0, grant}, 0);
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_state", {29'd0, dbg_state}, 0);
        wb_rst = 1'b1;

        // table-driven arbitration
        for (int v = 0; v < 7; v++) begin
            cur = vecs[v];
            wait_idle();
            @(posedge wb_clk);
            #1;
            if (cur.first == 2'b01) begin
                if (cur.req[0]) push_pkt(0, cur.b0, cur.n0);
                if (cur.req[1]) push_pkt(1, cur.b1, cur.n1);
            end else begin
                if (cur.req[1]) push_pkt(1, cur.b1, cur.n1);
                if (cur.req[0]) push_pkt(0, cur.b0, cur.n0);
            end
            fork
                begin if (cur.req[0]) send_pkt(0, cur.b0, cur.n0, 1'b1); end
                begin if (cur.req[1]) send_pkt(1, cur.b1, cur.n1, 1'b1); end
                begin
                    @(posedge wb_clk);
                    @(negedge wb_clk);
                    check($sformatf("vec%0d_first_grant", v), {30'd0, grant}, {30'd0, cur.first});
                    check($sformatf("vec%0d_first_ready", v), {30'd0, s1_ready, s0_ready}, {30'd0, cur.first});
                    check($sformatf("vec%0d_busy", v), {31'd0, busy}, 1);
                end
            join
            wait_idle();
            check($sformatf("vec%0d_grant_released", v), {30'd0, grant}, 0);
        end

        // next byte of the same packet starts 2 cycles after the UART goes idle
        wait_idle();
        exp_gap = 2;
        gap_en  = 1'b1;
        push_pkt(0, 24'h535251, 3);
        @(posedge wb_clk);
        #1;
        send_pkt(0, 24'h535251, 3, 1'b1);
        wait_idle();
        gap_en = 1'b0;

        // requester 1 arrives mid-packet: it must wait for requester 0's last byte
        push_pkt(0, 24'h333231, 3);
        push_pkt(1, 24'h000041, 1);
        @(posedge wb_clk);
        #1;
        fork
            send_pkt(0, 24'h333231, 3, 1'b1);
            begin
                repeat (5) @(posedge wb_clk);
                #1;
                set_req(1, 1'b1, 8'h41, 1'b1);
                @(negedge wb_clk);
                check("midpacket_s1_ready", {31'd0, s1_ready}, 0);
                check("midpacket_grant", {30'd0, grant}, 2'b01);
                send_pkt(1, 24'h000041, 1, 1'b1);
            end
        join
        wait_idle();

        // simultaneous start: 0 wins the first tie, 1 wins the next one against 0's second packet
        push_pkt(0, 24'h0000A1, 1);
        push_pkt(1, 24'h0000B1, 1);
        push_pkt(0, 24'h0000A2, 1);
        @(posedge wb_clk);
        #1;
        fork
            begin
                send_pkt(0, 24'h0000A1, 1, 1'b1);
                send_pkt(0, 24'h0000A2, 1, 1'b1);
            end
            send_pkt(1, 24'h0000B1, 1, 1'b1);
        join
        wait_idle();

        // back-to-back single-byte packets from requester 1: 3 cycles from UART idle to next start
        exp_gap = 3;
        gap_en  = 1'b1;
        push_pkt(1, 24'h000061, 1);
        push_pkt(1, 24'h000062, 1);
        push_pkt(1, 24'h000063, 1);
        @(posedge wb_clk);
        #1;
        send_pkt(1, 24'h000061, 1, 1'b1);
        send_pkt(1, 24'h000062, 1, 1'b1);
        send_pkt(1, 24'h000063, 1, 1'b1);
        wait_idle();
        gap_en = 1'b0;

        // reset while the UART is busy; no grant until it goes idle
        push_pkt(0, 24'h000077, 1);
        @(posedge wb_clk);
        #1;
        force_busy = 1'b1;
        fork
            send_pkt(0, 24'h000077, 1, 1'b1);
            begin
                bit bad;
                @(negedge wb_clk);
                wb_rst = 1'b0;
                #1;
                check("rst_transmit", {31'd0, transmit}, 0);
                check("rst_tx_byte", {24'd0, tx_byte}, 0);
                check("rst_ready", {30'd0, s1_ready, s0_ready}, 0);
                check("rst_grant", {30'd0, grant}, 0);
                check("rst_busy", {31'd0, busy}, 0);
                check("rst_timeout_err", {31'd0, timeout_err}, 0);
                check("rst_state", {29'd0, dbg_state}, 0);
                repeat (3) @(negedge wb_clk);
                wb_rst = 1'b1;
                bad = 1'b0;
                for (int i = 0; i < 50; i++) begin
                    @(negedge wb_clk);
                    if (transmit || grant != 2'b00) bad = 1'b1;
                end
                check("held_busy_no_grant", {31'd0, bad}, 0);
                exp_gap = 2;
                gap_en  = 1'b1;
                @(posedge wb_clk);
                #1;
                force_busy = 1'b0;
            end
        join
        wait_idle();
        gap_en = 1'b0;

        // timeout: requester 0 sends a non-last byte and then stalls; requester 1 is waiting
        push_pkt(0, 24'h000011, 1);
        push_pkt(1, 24'h000022, 1);
        @(posedge wb_clk);
        #1;
        fork
            send_pkt(0, 24'h000011, 1, 1'b0);
            begin
                repeat (5) @(posedge wb_clk);
                #1;
                send_pkt(1, 24'h000022, 1, 1'b1);
            end
        join
        wait_idle();
        check("timeout_pulse_count", tmo_seen, 1);
        check("timeout_cycles_after_fall", tmo_gap, 11);
        check("timeout_grant_cleared", {30'd0, tmo_grant}, 0);
        check("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
